// File: rtl/slot_machine_if.sv
// slot_machine_if -- player-side signal bundle of the slot machine.
//
// Player inputs : collect (cash-out request), credit[9:0] (money inserted, a
//                 changed nonzero value is a new deposit), bet[1:0]
//                 (01 = $1, 10 = $2, other = no bet), seed1[5:0], seed2[6:0],
//                 seed3[7:0] (reel seeds).
// Machine outputs: fund[9:0] (player balance), bet_1d[1:0] / bet_2d[1:0]
//                 (accepted-spin indicators), rnum1..rnum3[3:0] (reel symbols).
//
// master : the player / stimulus side, drives the inputs.
// slave  : the slot machine itself, drives the outputs.
interface slot_machine_if;
    logic       collect;
    logic [9:0] credit;
    logic [1:0] bet;
    logic [5:0] seed1;
    logic [6:0] seed2;
    logic [7:0] seed3;
    logic [9:0] fund;
    logic [1:0] bet_1d;
    logic [1:0] bet_2d;
    logic [3:0] rnum1;
    logic [3:0] rnum2;
    logic [3:0] rnum3;

    modport master (
        output collect, credit, bet, seed1, seed2, seed3,
        input  fund, bet_1d, bet_2d, rnum1, rnum2, rnum3
    );

    modport slave (
        input  collect, credit, bet, seed1, seed2, seed3,
        output fund, bet_1d, bet_2d, rnum1, rnum2, rnum3
    );
endinterface

// File: rtl/slot_machine.sv
// slot_machine -- single-cycle three-reel slot machine.
//
// Ports:
//   clock : rising-edge system clock.
//   reset : synchronous, active-high; clears balance, reels, bet flags and
//           the remembered credit value.
//   bus   : slot_machine_if.slave -- player inputs (collect, credit, bet,
//           seeds) and registered outputs (fund, bet_1d, bet_2d, rnum1-3).
//
// Each edge: a changed nonzero credit is added to the balance; a $1/$2 bet
// that the (deposit-inclusive) balance covers spins the reels, which take
// seedN mod 10, and pays 10x the bet for three of a kind or 2x for a pair.
// The balance saturates at 1023. collect zeroes balance, reels and flags.
module slot_machine (
    input  logic           clock,
    input  logic           reset,
    slot_machine_if.slave  bus
);

    logic [9:0]  credit_prev;

    logic [9:0]  deposit;
    logic [10:0] avail;
    logic [1:0]  bet_amt;
    logic        accept;
    logic [3:0]  sym1, sym2, sym3;
    logic [4:0]  payout;
    logic [11:0] spin_total;

    logic [9:0]  fund_next;
    logic [1:0]  bet_1d_next, bet_2d_next;
    logic [3:0]  rnum1_next, rnum2_next, rnum3_next;

    // Reel symbols; the remainders are below 10, so four bits suffice.
    assign sym1 = 4'(bus.seed1 % 6'd10);
    assign sym2 = 4'(bus.seed2 % 7'd10);
    assign sym3 = 4'(bus.seed3 % 8'd10);

    // A credit value is a deposit only on the edge where it first appears;
    // holding it steady must not add it again.
    assign deposit = ((bus.credit != credit_prev) && (bus.credit != 10'd0))
                     ? bus.credit : 10'd0;

    // Deposit is counted before the affordability check; 11 bits hold 2046.
    assign avail = {1'b0, bus.fund} + {1'b0, deposit};

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        bet_amt = 2'd0;
        payout  = 5'd0;
        case (bus.bet)
            2'b01:   bet_amt = 2'd1;
            2'b10:   bet_amt = 2'd2;
            default: bet_amt = 2'd0;
        endcase

        if ((sym1 == sym2) && (sym2 == sym3))
            payout = 5'd10 * {3'd0, bet_amt};
        else if ((sym1 == sym2) || (sym1 == sym3) || (sym2 == sym3))
            payout = 5'd2 * {3'd0, bet_amt};
        else
            payout = 5'd0;
    end

    assign accept = (bet_amt != 2'd0) && !bus.collect
                    && (avail >= {9'd0, bet_amt});

    // avail - bet + payout can reach 2064, hence 12 bits before saturating.
    assign spin_total = {1'b0, avail} - {10'd0, bet_amt} + {7'd0, payout};

    always_comb begin
        fund_next   = bus.fund;
        bet_1d_next = 2'b00;
        bet_2d_next = 2'b00;
        rnum1_next  = bus.rnum1;
        rnum2_next  = bus.rnum2;
        rnum3_next  = bus.rnum3;

        if (bus.collect) begin
            // Cash-out wins over any bet or deposit presented this cycle.
            fund_next  = 10'd0;
            rnum1_next = 4'd0;
            rnum2_next = 4'd0;
            rnum3_next = 4'd0;
        end else if (accept) begin
            fund_next   = (spin_total > 12'd1023) ? 10'd1023 : spin_total[9:0];
            bet_1d_next = (bet_amt == 2'd1) ? 2'b01 : 2'b00;
            bet_2d_next = (bet_amt == 2'd2) ? 2'b10 : 2'b00;
            rnum1_next  = sym1;
            rnum2_next  = sym2;
            rnum3_next  = sym3;
        end else begin
            // No spin (no bet, or unaffordable): just bank any deposit.
            fund_next = (avail > 11'd1023) ? 10'd1023 : avail[9:0];
        end
    end

    // NOTE: registers are updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            credit_prev <= 10'd0;
            bus.fund    <= 10'd0;
            bus.bet_1d  <= 2'b00;
            bus.bet_2d  <= 2'b00;
            bus.rnum1   <= 4'd0;
            bus.rnum2   <= 4'd0;
            bus.rnum3   <= 4'd0;
        end else begin
            // Tracks credit on every edge, collect cycles included, so a
            // discarded deposit is not re-added once collect drops.
            credit_prev <= bus.credit;
            bus.fund    <= fund_next;
            bus.bet_1d  <= bet_1d_next;
            bus.bet_2d  <= bet_2d_next;
            bus.rnum1   <= rnum1_next;
            bus.rnum2   <= rnum2_next;
            bus.rnum3   <= rnum3_next;
        end
    end

endmodule

// File: tb/tb_slot_machine.sv
// tb_slot_machine -- self-checking bench for slot_machine.
// Directed scenarios followed by randomized play, every cycle compared
// against a behavioural model of the machine's rules.
module tb_slot_machine;

    logic clock;
    logic reset;

    slot_machine_if sm_if ();

    slot_machine dut (
        .clock (clock),
        .reset (reset),
        .bus   (sm_if)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model state (plain integers).
    int m_fund, m_prev, m_r1, m_r2, m_r3, m_b1, m_b2;

    task automatic chk(input string name, input logic [31:0] observed,
                       input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    // Behavioural reference: apply one clock edge of the machine's rules.
    task automatic model_edge(input bit rst, input bit col, input int cr,
                              input int bt, input int s1, input int s2,
                              input int s3);
        int d, a, b, p, n1, n2, n3;
        if (rst) begin
            m_fund = 0; m_prev = 0; m_r1 = 0; m_r2 = 0; m_r3 = 0;
            m_b1 = 0; m_b2 = 0;
            return;
        end
        d = (cr != m_prev && cr != 0) ? cr : 0;
        a = m_fund + d;
        b = (bt == 1) ? 1 : (bt == 2) ? 2 : 0;
        m_prev = cr;
        if (col) begin
            m_fund = 0; m_r1 = 0; m_r2 = 0; m_r3 = 0; m_b1 = 0; m_b2 = 0;
        end else if (b != 0 && a >= b) begin
            n1 = s1 % 10; n2 = s2 % 10; n3 = s3 % 10;
            if (n1 == n2 && n2 == n3)                  p = 10 * b;
            else if (n1 == n2 || n1 == n3 || n2 == n3) p = 2 * b;
            else                                       p = 0;
            m_fund = (a - b + p > 1023) ? 1023 : a - b + p;
            m_r1 = n1; m_r2 = n2; m_r3 = n3;
            m_b1 = (b == 1) ? 1 : 0;
            m_b2 = (b == 2) ? 2 : 0;
        end else begin
            m_fund = (a > 1023) ? 1023 : a;
            m_b1 = 0; m_b2 = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fund"},   32'(sm_if.fund),   32'(m_fund));
        chk({tag, ".bet_1d"}, 32'(sm_if.bet_1d), 32'(m_b1));
        chk({tag, ".bet_2d"}, 32'(sm_if.bet_2d), 32'(m_b2));
        chk({tag, ".rnum1"},  32'(sm_if.rnum1),  32'(m_r1));
        chk({tag, ".rnum2"},  32'(sm_if.rnum2),  32'(m_r2));
        chk({tag, ".rnum3"},  32'(sm_if.rnum3),  32'(m_r3));
    endtask

    // Drive one cycle's inputs, clock once, then compare 1 time unit later.
    task automatic step(input string tag, input bit rst, input bit col,
                        input int cr, input int bt, input int s1,
                        input int s2, input int s3);
        reset         = rst;
        sm_if.collect = col;
        sm_if.credit  = cr[9:0];
        sm_if.bet     = bt[1:0];
        sm_if.seed1   = s1[5:0];
        sm_if.seed2   = s2[6:0];
        sm_if.seed3   = s3[7:0];
        @(posedge clock);
        model_edge(rst, col, cr, bt, s1, s2, s3);
        #1;
        check_all(tag);
    endtask

    initial begin
        int cr;
        clock = 1'b0;
        reset = 1'b1;
        sm_if.collect = 1'b0;
        sm_if.credit  = '0;
        sm_if.bet     = '0;
        sm_if.seed1   = '0;
        sm_if.seed2   = '0;
        sm_if.seed3   = '0;
        m_fund = 0; m_prev = 0; m_r1 = 0; m_r2 = 0; m_r3 = 0;
        m_b1 = 0; m_b2 = 0;

        // Reset has priority over collect, credit and bet.
        step("reset_prio", 1, 1, 300, 2, 5, 5, 5);
        step("reset",      1, 0, 0,   0, 0, 0, 0);

        // Deposit, pair win, no-match loss.
        step("dep4", 0, 0, 4, 0, 0, 0, 0);
        chk("dep4.fund_const", 32'(sm_if.fund), 32'd4);
        step("spin_115", 0, 0, 4, 2, 1, 1, 5);
        chk("spin_115.fund_const", 32'(sm_if.fund), 32'd6);
        step("spin_531", 0, 0, 4, 2, 45, 3, 1);
        chk("spin_531.fund_const", 32'(sm_if.fund), 32'd4);

        // Three of a kind on a $1 bet.
        step("spin_444", 0, 0, 4, 1, 4, 4, 4);
        chk("spin_444.fund_const", 32'(sm_if.fund), 32'd13);

        // Unaffordable bet ignored (fund=1, bet $2).
        step("collect_a", 0, 1, 0, 0, 0, 0, 0);
        step("dep1",      0, 0, 1, 0, 0, 0, 0);
        step("poor_bet",  0, 0, 1, 2, 7, 7, 7);
        chk("poor_bet.fund_const", 32'(sm_if.fund), 32'd1);

        // Same-cycle deposit funds the bet.
        step("collect_b", 0, 1, 4, 0, 0, 0, 0);
        step("dep_bet",   0, 0, 50, 2, 1, 2, 3);
        chk("dep_bet.fund_const", 32'(sm_if.fund), 32'd48);

        // Saturation at 1023; held credit and held bet keep spinning.
        step("collect_c", 0, 1, 0, 0, 0, 0, 0);
        step("dep1020",   0, 0, 1020, 0, 0, 0, 0);
        step("sat_spin",  0, 0, 1020, 2, 5, 5, 5);
        chk("sat_spin.fund_const", 32'(sm_if.fund), 32'd1023);
        step("held_bet",  0, 0, 1020, 2, 12, 34, 56);
        chk("held_bet.fund_const", 32'(sm_if.fund), 32'd1021);

        // Collect overrides bet and a changing credit; then credit 50 -> 10.
        step("collect_d", 0, 1, 50, 2, 9, 9, 9);
        chk("collect_d.fund_const", 32'(sm_if.fund), 32'd0);
        step("dep10",     0, 0, 10, 0, 0, 0, 0);
        chk("dep10.fund_const", 32'(sm_if.fund), 32'd10);

        // Randomized play.
        cr = 10;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0)
                cr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1023))
                                                 : int'($urandom_range(0, 20));
            step("rand",
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 24) == 0,
                 cr,
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 127)),
                 int'($urandom_range(0, 255)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slot_machine.md
SLOT_MACHINE -- requirements
Module: slot_machine

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  input  1  rising-edge system clock; all state updates on this edge.
REQ-003 reset  input  1  synchronous, active-high; forces all registers to reset values.
REQ-004 collect  input  1  player cash-out request.
REQ-005 credit  input  10  money inserted, unsigned dollars; a new value is a new deposit.
REQ-006 bet  input  2  bet request: 2'b01 = $1, 2'b10 = $2, 2'b00/2'b11 = no bet.
REQ-007 seed1  input  6  reel-1 seed, unsigned.
REQ-008 seed2  input  7  reel-2 seed, unsigned.
REQ-009 seed3  input  8  reel-3 seed, unsigned.
REQ-010 fund  output  10  registered player balance, unsigned dollars.
REQ-011 bet_1d  output  2  registered; 2'b01 when the last cycle accepted a $1 spin, else 2'b00.
REQ-012 bet_2d  output  2  registered; 2'b10 when the last cycle accepted a $2 spin, else 2'b00.
REQ-013 rnum1, rnum2, rnum3  output  4 each  registered reel symbols, range 0-9.

Function
REQ-014 An internal 10-bit credit_prev register SHALL hold credit as sampled on the previous edge.
REQ-015 Deposit: when credit != credit_prev and credit != 0, the deposit amount D SHALL be credit; otherwise D = 0.
REQ-016 credit_prev SHALL load credit on every edge, including collect cycles.
REQ-017 Available balance: A = fund + D, computed 11 bits wide.
REQ-018 Bet amount: B = 1 for 2'b01, B = 2 for 2'b10, B = 0 otherwise.
REQ-019 A spin SHALL be accepted when B != 0, collect = 0 and A >= B.
REQ-020 On an accepted spin, rnumN SHALL load seedN mod 10 (N = 1, 2, 3).
REQ-021 Payout P SHALL be 10*B when all three new symbols are equal.
REQ-022 Payout P SHALL be 2*B when exactly two of the three new symbols are equal.
REQ-023 Payout P SHALL be 0 when no two of the new symbols are equal.
REQ-024 On an accepted spin, fund SHALL become min(A - B + P, 1023).
REQ-025 On an accepted spin, bet_1d/bet_2d SHALL reflect B per REQ-011/012.
REQ-026 With no accepted spin and collect = 0, fund SHALL become min(A, 1023).
REQ-027 With no accepted spin, rnum1-3 SHALL hold their values and bet_1d/bet_2d SHALL be 2'b00.
REQ-028 A bet with A < B SHALL be ignored: no fund deduction, rnums held.
REQ-029 A deposit in the same cycle as a bet SHALL be counted before the affordability check.
REQ-030 Collect: when collect = 1, fund, rnum1-3, bet_1d and bet_2d SHALL all become 0.
REQ-031 Collect SHALL override any bet or deposit presented in the same cycle; that deposit is discarded.
REQ-032 A bet SHALL spin on every edge while it is held; there is no edge detection on bet.
REQ-033 A held constant credit SHALL NOT be re-added.
REQ-034 There is no internal state machine beyond the registers listed; a $1-2 spin completes in one cycle.

Reset
REQ-035 With reset = 1 at an edge, fund, credit_prev, rnum1-3, bet_1d and bet_2d SHALL become 0.
REQ-036 reset SHALL have priority over collect, credit and bet.
REQ-037 The first deposit after reset SHALL be any nonzero credit.

Verification
REQ-038 reset; credit=4, bet=00 -> fund=4. Then bet=10 with seeds 1/1/5 -> rnum=1,1,5; bet_2d=10; fund=6. Then seeds 45/3/1, bet=10 -> rnum=5,3,1; fund=4.
REQ-039 fund=4; bet=01 with seeds 4/4/4 -> rnum=4,4,4; bet_1d=01; fund=13.
REQ-040 fund=1; bet=10 -> fund stays 1, rnums unchanged, bet_2d=00.
REQ-041 fund=0, credit_prev=4; credit=50 and bet=10 in the same cycle, seeds 1/2/3 -> fund=48.
REQ-042 fund=1020; bet=10 with seeds 5/5/5 -> fund=1023 (saturated).
REQ-043 collect=1 with bet=10 and credit changing in the same cycle -> fund=0 and rnums=0. Then after collect=0, credit 50->10 -> fund=10.
